// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter and its round-robin picker.
// Keeps the state encoding and width arithmetic in one place for every consumer.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } arb_state_e;

    localparam int DEFAULT_DATA_W = 8;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

    // Index/counter width that never collapses to zero bits.
    function automatic int idx_w(input int value);
        return (clog2(value) > 0) ? clog2(value) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or after last_grant+1, with wrap.
// Generic enough to be reused by other bus arbiters.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter  int N_REQ = 3,
    localparam int IW    = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last_grant,
    output logic             any_req,
    output logic [IW-1:0]    pick
);

    int idx;

    // Scan from the farthest candidate to the nearest so the nearest one wins.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
        any_req = 1'b0;
        pick    = '0;
        idx     = 0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = int'(last_grant) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (req[idx]) begin
                any_req = 1'b1;
                pick    = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between N_REQ requesters, packet by packet in round-robin order,
// sequencing the write/busy handshake per byte and releasing a stalled grant after a timeout.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter  int N_REQ        = 3,
    parameter  int DATA_W       = DEFAULT_DATA_W,
    parameter  int IDLE_TIMEOUT = 1024,
    localparam int GW           = idx_w(N_REQ),
    localparam int TW           = idx_w(IDLE_TIMEOUT + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    input  logic [N_REQ-1:0]          req_last,
    output logic [N_REQ-1:0]          req_ready,
    output logic [DATA_W-1:0]         tx_data,
    output logic                      tx_wr,
    input  logic                      tx_busy,
    output logic [GW-1:0]             grant_id,
    output logic                      active,
    output logic                      timeout_evt
);

    arb_state_e        state_q, state_d;
    logic [GW-1:0]     grant_q, grant_d;
    logic [GW-1:0]     last_grant_q, last_grant_d;
    logic [TW-1:0]     idle_cnt_q, idle_cnt_d;
    logic              last_flag_q, last_flag_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              tx_wr_q, tx_wr_d;
    logic              timeout_evt_q, timeout_evt_d;

    logic              any_req;
    logic [GW-1:0]     pick;
    logic [DATA_W-1:0] req_bytes [N_REQ];
    logic              grant_valid;
    logic              grant_last;

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign req_bytes[i] = req_data[i*DATA_W +: DATA_W];
    end

    assign grant_valid = req_valid[grant_q];
    assign grant_last  = req_last[grant_q];

    rr_pick #(
        .N_REQ      (N_REQ)
    ) u_rr_pick (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .any_req    (any_req),
        .pick       (pick)
    );

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        idle_cnt_d    = idle_cnt_q;
        last_flag_d   = last_flag_q;
        tx_data_d     = tx_data_q;
        tx_wr_d       = 1'b0;
        timeout_evt_d = 1'b0;
        req_ready     = '0;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d    = pick;
                    idle_cnt_d = '0;
                    state_d    = SEND;
                end
            end
            SEND: begin
                // A busy UART with data waiting is a hold, not an idle: the timeout only counts missing data.
                if (grant_valid) begin
                    if (!tx_busy) begin
                        req_ready[grant_q] = 1'b1;
                        tx_data_d          = req_bytes[grant_q];
                        tx_wr_d            = 1'b1;
                        last_flag_d        = grant_last;
                        state_d            = WAIT_HI;
                    end
                end else if (IDLE_TIMEOUT != 0) begin
                    if (idle_cnt_q == TW'(IDLE_TIMEOUT - 1)) begin
                        last_grant_d  = grant_q;
                        timeout_evt_d = 1'b1;
                        state_d       = IDLE;
                    end else begin
                        idle_cnt_d = idle_cnt_q + TW'(1);
                    end
                end
            end
            WAIT_HI: begin
                if (tx_busy) state_d = WAIT_LO;
            end
            WAIT_LO: begin
                if (!tx_busy) begin
                    if (last_flag_q) begin
                        last_grant_d = grant_q;
                        state_d      = IDLE;
                    end else begin
                        idle_cnt_d = '0;
                        state_d    = SEND;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // last_grant resets to the top index so the first arbitration favours requester 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            last_grant_q  <= GW'(N_REQ - 1);
            idle_cnt_q    <= '0;
            last_flag_q   <= 1'b0;
            tx_data_q     <= '0;
            tx_wr_q       <= 1'b0;
            timeout_evt_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            idle_cnt_q    <= idle_cnt_d;
            last_flag_q   <= last_flag_d;
            tx_data_q     <= tx_data_d;
            tx_wr_q       <= tx_wr_d;
            timeout_evt_q <= timeout_evt_d;
        end
    end

    assign tx_data     = tx_data_q;
    assign tx_wr       = tx_wr_q;
    assign grant_id    = grant_q;
    assign active      = (state_q != IDLE);
    assign timeout_evt = timeout_evt_q;

endmodule
